// File: rtl/subtractor_digit_serial_16bit.sv
// Digit-serial subtractor: D = A - B - Bin, least-significant digit first.
// One DIGIT-wide slice is handled per RUN cycle, with a single borrow flip-flop between cycles.
module subtractor_digit_serial_16bit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned DW   = DIGIT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             a_msb;
    logic             b_msb;

    logic [DW-1:0]    dsub;
    logic [WIDTH-1:0] res_shift;
    logic             last;
    logic             accept;

    // One digit of subtraction; the extra top bit is the outgoing borrow
    always_comb begin
        dsub      = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]} - DW'(brw);
        res_shift = (res_sr >> DIGIT) | (WIDTH'(dsub[DIGIT-1:0]) << (WIDTH - DIGIT));
        last      = (cnt == CW'(NDIG - 1));
        accept    = start && (state != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, digit shifting and result/flag update at completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            V      <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
            if (accept) begin
                a_sr   <= A;
                b_sr   <= B;
                brw    <= Bin;
                cnt    <= '0;
                res_sr <= '0;
                a_msb  <= A[WIDTH-1];
                b_msb  <= B[WIDTH-1];
            end else if (state == RUN) begin
                a_sr   <= a_sr >> DIGIT;
                b_sr   <= b_sr >> DIGIT;
                res_sr <= res_shift;
                brw    <= dsub[DIGIT];
                cnt    <= cnt + CW'(1);
                if (last) begin
                    D    <= res_shift;
                    Bout <= dsub[DIGIT];
                    V    <= (a_msb != b_msb) && (res_shift[WIDTH-1] != a_msb);
                end
            end
        end
    end

endmodule

// File: tb/tb_subtractor_digit_serial_16bit.sv
// Scoreboard bench for the digit-serial subtractor: DIGIT=4 directed tests,
// DIGIT=1 and DIGIT=16 instances checked against a golden model with random operands.
module tb_subtractor_digit_serial_16bit;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start_r;
    logic [W-1:0] a, b;
    logic         bin;

    logic         busy4, done4, bout4, v4;
    logic [W-1:0] d4;
    logic         busy1, done1, bout1, v1;
    logic [W-1:0] d1;
    logic         busy16, done16, bout16, v16;
    logic [W-1:0] d16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] sb4[$];
    logic [W+1:0] sb1[$];
    logic [W+1:0] sb16[$];
    logic [W+1:0] e4, e1, e16;
    logic [W-1:0] prev_d;

    always #5 clk = ~clk;

    subtractor_digit_serial_16bit #(.WIDTH(W), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
        .busy(busy4), .done(done4), .D(d4), .Bout(bout4), .V(v4));

    subtractor_digit_serial_16bit #(.WIDTH(W), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r), .A(a), .B(b), .Bin(bin),
        .busy(busy1), .done(done1), .D(d1), .Bout(bout1), .V(v1));

    subtractor_digit_serial_16bit #(.WIDTH(W), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_r), .A(a), .B(b), .Bin(bin),
        .busy(busy16), .done(done16), .D(d16), .Bout(bout16), .V(v16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden result packed as {V, Bout, D}
    function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic bi);
        logic [W:0] full;
        logic       ov;
        full = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
        ov   = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        return {ov, full};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (sb4.size() == 0) check("sb4_unexpected_done", 32'd1, 32'd0);
            else begin
                e4 = sb4.pop_front();
                check("d4", 32'(d4), 32'(e4[W-1:0]));
                check("bout4", 32'(bout4), 32'(e4[W]));
                check("v4", 32'(v4), 32'(e4[W+1]));
            end
        end
        if (rst_n && done1) begin
            if (sb1.size() == 0) check("sb1_unexpected_done", 32'd1, 32'd0);
            else begin
                e1 = sb1.pop_front();
                check("d1", 32'(d1), 32'(e1[W-1:0]));
                check("bout1", 32'(bout1), 32'(e1[W]));
                check("v1", 32'(v1), 32'(e1[W+1]));
            end
        end
        if (rst_n && done16) begin
            if (sb16.size() == 0) check("sb16_unexpected_done", 32'd1, 32'd0);
            else begin
                e16 = sb16.pop_front();
                check("d16", 32'(d16), 32'(e16[W-1:0]));
                check("bout16", 32'(bout16), 32'(e16[W]));
                check("v16", 32'(v16), 32'(e16[W+1]));
            end
        end
    end

    // Issue one op on the DIGIT=4 instance, check output hold, busy length and done pulse
    task automatic run_op4(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int n;
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        sb4.push_back(golden(x, y, bi));
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; bin = ~bi;
        check("hold_d4", 32'(d4), 32'(prev_d));
        n = 0;
        while (busy4 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy4_cycles", 32'(n), 32'd4);
        check("done4_pulse", 32'(done4), 32'd1);
        @(negedge clk);
        check("done4_clear", 32'(done4), 32'd0);
        prev_d = d4;
    endtask

    initial begin
        int n, n1, n16;
        logic [W-1:0] ra, rb;
        logic         rbi;
        rst_n = 1'b0; start = 1'b0; start_r = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev_d = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_d", 32'(d4), 32'd0);
        check("rst_bout_v", 32'({bout4, v4}), 32'd0);
        rst_n = 1'b1;

        run_op4(16'h0000, 16'h0000, 1'b0);
        run_op4(16'h246B, 16'h0C15, 1'b0);
        check("d4_246b", 32'(d4), 32'h1856);
        run_op4(16'h0C15, 16'h246B, 1'b0);
        check("d4_swap", 32'({bout4, d4}), 32'h1E7AA);
        run_op4(16'h8000, 16'h0001, 1'b0);
        check("v4_ovf", 32'({v4, bout4, d4}), 32'h27FFF);
        run_op4(16'h0000, 16'h0000, 1'b1);
        check("d4_bin", 32'({bout4, d4}), 32'h1FFFF);

        // Ignored start during RUN, then back-to-back start in the DONE cycle
        @(negedge clk);
        a = 16'h246B; b = 16'h0C15; bin = 1'b0; start = 1'b1;
        sb4.push_back(golden(16'h246B, 16'h0C15, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done4 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_done", 32'(done4), 32'd1);
        check("b2b_first_d", 32'(d4), 32'h1856);
        a = 16'h1000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        sb4.push_back(golden(16'h1000, 16'h0001, 1'b0));
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy4), 32'd1);
        n = 0;
        while (busy4 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_busy_cycles", 32'(n), 32'd4);
        check("b2b_second_d", 32'(d4), 32'h0FFF);
        @(negedge clk);
        prev_d = d4;

        // Asynchronous reset in RUN cycle 3 aborts with no done pulse
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy4), 32'd0);
        check("arst_done", 32'(done4), 32'd0);
        check("arst_d", 32'(d4), 32'd0);
        check("arst_flags", 32'({bout4, v4}), 32'd0);
        repeat (6) @(negedge clk);
        check("arst_no_done", 32'(done4), 32'd0);
        rst_n = 1'b1;
        prev_d = '0;
        run_op4(16'h5555, 16'h1111, 1'b1);
        check("post_rst_d", 32'(d4), 32'h4443);

        // Random operands on DIGIT=1 and DIGIT=16 instances
        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rbi = 1'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h7FFF; rbi = 1'b1; end
            @(negedge clk);
            a = ra; b = rb; bin = rbi; start_r = 1'b1;
            sb1.push_back(golden(ra, rb, rbi));
            sb16.push_back(golden(ra, rb, rbi));
            @(negedge clk);
            start_r = 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            n = 0; n1 = 0; n16 = 0;
            while ((busy1 || busy16) && n < 40) begin
                if (busy1)  n1++;
                if (busy16) n16++;
                n++;
                @(negedge clk);
            end
            check("busy1_cycles", 32'(n1), 32'd16);
            check("busy16_cycles", 32'(n16), 32'd1);
        end
        repeat (3) @(negedge clk);
        check("sb4_drained", 32'(sb4.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb16_drained", 32'(sb16.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
